// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding, datapath width and opcode-class helpers
// used by the ALU scheduler and its starvation guard.
package alu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_LSL   = 4'h4,
    OP_CMP   = 4'h5,
    OP_SET   = 4'h6,
    OP_LDR   = 4'h7,
    OP_STR   = 4'h8,
    OP_B     = 4'h9,
    OP_BEQ   = 4'hA,
    OP_BGE   = 4'hB,
    OP_STALL = 4'hC
  } alu_op_e;

  // B, BEQ and BGE are resolved by the scheduler, not computed by the ALU.
  function automatic logic is_branch(input alu_op_e op);
    return (op == OP_B) || (op == OP_BEQ) || (op == OP_BGE);
  endfunction

  // Opcodes 0..8 return the ALU result; branches, STALL and unknown
  // encodings return zero.
  function automatic logic is_data_op(input alu_op_e op);
    return op <= OP_STR;
  endfunction

endpackage

// File: rtl/alu_starve_guard.sv
// alu_starve_guard: counts consecutive cycles the auxiliary requester has
// been refused and forces it through once the count reaches STARVE_LIMIT.
//   clk, rst      clock, asynchronous active-high reset
//   x_valid       auxiliary request pending
//   x_ready       auxiliary grant this cycle (from the scheduler)
//   force_grant   auxiliary must win this cycle
module alu_starve_guard #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic x_valid,
  input  logic x_ready,
  output logic force_grant
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the clock edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!x_valid || x_ready) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Depends only on the counter and x_valid, so x_ready can be derived
  // from it without a combinational loop.
  assign force_grant = x_valid && (starve_cnt == LIMIT);

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: arbitrates the shared execute-stage ALU between the primary
// (p_*) and auxiliary (x_*) requesters, holds the granted operation in a
// single issue stage, returns a registered response, owns the Z/N flags and
// resolves B/BEQ/BGE.
//   clk, rst                      clock, asynchronous active-high reset
//   p_valid/p_ready, p_op/a/b     primary request
//   x_valid/x_ready, x_op/a/b     auxiliary request
//   flush                         kill the operation in the issue stage
//   alu_a, alu_b, alu_sel         drive the external combinational ALU
//   alu_out                       ALU result
//   rsp_valid, rsp_id, rsp_data   registered response (id 0 = primary)
//   flag_z, flag_n                architectural flags
//   br_valid, br_taken            branch resolution in the issue cycle
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int DATA_W       = alu_pkg::DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [3:0]        p_op,
  input  logic [DATA_W-1:0] p_a,
  input  logic [DATA_W-1:0] p_b,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [3:0]        x_op,
  input  logic [DATA_W-1:0] x_a,
  input  logic [DATA_W-1:0] x_b,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              flag_z,
  output logic              flag_n,
  output logic              br_valid,
  output logic              br_taken
);

  logic force_grant;
  logic p_hs, x_hs;

  logic              iss_valid;
  logic              iss_id;
  alu_op_e           iss_op;
  logic [DATA_W-1:0] iss_a;
  logic [DATA_W-1:0] iss_b;
  logic              retire;

  alu_starve_guard #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_guard (
    .clk         (clk),
    .rst         (rst),
    .x_valid     (x_valid),
    .x_ready     (x_ready),
    .force_grant (force_grant)
  );

  // Readiness never looks at flush or issue occupancy: the issue stage is
  // replaced every cycle, so there is no internal reason to stall.
  assign x_ready = force_grant || !p_valid;
  assign p_ready = !force_grant;

  // Mutually exclusive by construction: x_ready with p_valid implies force,
  // which drops p_ready.
  assign p_hs = p_valid && p_ready;
  assign x_hs = x_valid && x_ready;

  // The op in issue completes unless it is being flushed this cycle.
  assign retire = iss_valid && !flush;

  // NOTE: every register here is reset, including the operand/data fields,
  // so the ALU-facing and response outputs are clean zero right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_id    <= 1'b0;
      iss_op    <= OP_STALL;
      iss_a     <= '0;
      iss_b     <= '0;
    end else begin
      // A request granted alongside a flush still loads: the flush only
      // kills the op currently in issue.
      iss_valid <= p_hs || x_hs;
      if (x_hs) begin
        iss_id <= 1'b1;
        iss_op <= alu_op_e'(x_op);
        iss_a  <= x_a;
        iss_b  <= x_b;
      end else if (p_hs) begin
        iss_id <= 1'b0;
        iss_op <= alu_op_e'(p_op);
        iss_a  <= p_a;
        iss_b  <= p_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= retire;
      if (retire) begin
        rsp_id   <= iss_id;
        rsp_data <= is_data_op(iss_op) ? alu_out : '0;
      end
    end
  end

  // Written at the end of the CMP's issue cycle, so a branch issued in the
  // very next cycle already reads the new flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (retire && (iss_op == OP_CMP)) begin
      flag_z <= (alu_out == '0);
      flag_n <= alu_out[DATA_W-1];
    end
  end

  assign alu_a   = iss_valid ? iss_a : '0;
  assign alu_b   = iss_valid ? iss_b : '0;
  assign alu_sel = iss_valid ? iss_op : OP_STALL;

  // NOTE: outputs of a combinational block get a default first so no path
  // through the case leaves them unassigned (which would infer a latch).
  always_comb begin
    br_valid = 1'b0;
    br_taken = 1'b0;
    if (retire && is_branch(iss_op)) begin
      br_valid = 1'b1;
      case (iss_op)
        OP_B:    br_taken = 1'b1;
        OP_BEQ:  br_taken = flag_z;
        OP_BGE:  br_taken = !flag_n;
        default: br_taken = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed testbench for alu_scheduler with a behavioural ALU model and a
// response scoreboard.
module tb_alu_scheduler;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         p_valid, x_valid, flush;
  logic         p_ready, x_ready;
  logic [3:0]   p_op, x_op, alu_sel;
  logic [W-1:0] p_a, p_b, x_a, x_b, alu_a, alu_b, alu_out, rsp_data;
  logic         rsp_valid, rsp_id, flag_z, flag_n, br_valid, br_taken;

  typedef struct {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_scheduler #(.DATA_W(W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_ready(p_ready), .p_op(p_op), .p_a(p_a), .p_b(p_b),
    .x_valid(x_valid), .x_ready(x_ready), .x_op(x_op), .x_a(x_a), .x_b(x_b),
    .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .flag_z(flag_z), .flag_n(flag_n), .br_valid(br_valid), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  // Behavioural execute-stage ALU.
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      4'h0: alu_out = alu_a + alu_b;
      4'h1: alu_out = alu_a - alu_b;
      4'h2: alu_out = alu_a & alu_b;
      4'h3: alu_out = alu_a | alu_b;
      4'h4: alu_out = alu_a << alu_b[3:0];
      4'h5: alu_out = alu_a - alu_b;
      4'h6: alu_out = alu_b;
      4'h7: alu_out = alu_a + alu_b;
      4'h8: alu_out = alu_a + alu_b;
      default: alu_out = 16'hDEAD;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard: every response is popped and compared at the falling edge.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rsp_unexpected: observed id %0d data 0x%0h expected none",
               rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_valid = 1'b0; x_valid = 1'b0; flush = 1'b0;
    p_op = 4'hC; x_op = 4'hC; p_a = '0; p_b = '0; x_a = '0; x_b = '0;
  endtask

  task automatic drive_p(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    p_valid = 1'b1; p_op = op; p_a = a; p_b = b;
  endtask

  task automatic push(input logic id, input logic [W-1:0] data);
    exp_t e;
    e.id = id;
    e.data = data;
    sb.push_back(e);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cyc(); cyc();
    // Reset state.
    check("reset_alu_sel", 32'(alu_sel), 32'hC);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_flags", {30'd0, flag_z, flag_n}, 0);
    rst = 1'b0;
    cyc();

    // Primary ADD alone: issue next cycle, response the cycle after.
    drive_p(4'h0, 16'h0003, 16'h0004);
    check("add_p_ready", 32'(p_ready), 1);
    push(1'b0, 16'h0007);
    cyc();
    idle();
    check("add_issue_sel", 32'(alu_sel), 32'h0);
    check("add_issue_ops", {alu_a, alu_b}, {16'h0003, 16'h0004});
    check("add_rsp_early", 32'(rsp_valid), 0);
    cyc();
    check("add_rsp_valid", 32'(rsp_valid), 1);
    check("add_flags", {30'd0, flag_z, flag_n}, 0);
    cyc();
    check("add_rsp_single", 32'(rsp_valid), 0);

    // Starvation: both ports held high -> 4 primary grants then 1 auxiliary.
    for (int i = 0; i < 10; i++) begin
      drive_p(4'h0, 16'(i), 16'h0001);
      x_valid = 1'b1; x_op = 4'h1; x_a = 16'd100; x_b = 16'(i);
      #1;
      if (i % 5 == 4) begin
        check("starve_p_ready", 32'(p_ready), 0);
        check("starve_x_ready", 32'(x_ready), 1);
        push(1'b1, 16'(100 - i));
      end else begin
        check("starve_p_ready", 32'(p_ready), 1);
        check("starve_x_ready", 32'(x_ready), 0);
        push(1'b0, 16'(i + 1));
      end
      cyc();
    end
    idle();
    cyc(); cyc();

    // CMP 5,5 then BEQ back-to-back.
    drive_p(4'h5, 16'd5, 16'd5);
    push(1'b0, 16'h0000);
    cyc();
    drive_p(4'hA, 16'd0, 16'd0);
    push(1'b0, 16'h0000);
    cyc();
    idle();
    check("beq_flag_z", 32'(flag_z), 1);
    check("beq_br_valid", 32'(br_valid), 1);
    check("beq_br_taken", 32'(br_taken), 1);
    cyc();
    check("beq_br_done", 32'(br_valid), 0);

    // CMP 3,5 then BGE.
    drive_p(4'h5, 16'd3, 16'd5);
    push(1'b0, 16'hFFFE);
    cyc();
    drive_p(4'hB, 16'd0, 16'd0);
    push(1'b0, 16'h0000);
    cyc();
    idle();
    check("bge_flags", {30'd0, flag_z, flag_n}, 32'b01);
    check("bge_br_valid", 32'(br_valid), 1);
    check("bge_br_taken", 32'(br_taken), 0);
    cyc(); cyc();

    // Flush while CMP 7,7 is in issue; an ADD accepted the same cycle survives.
    drive_p(4'h5, 16'd7, 16'd7);
    cyc();
    flush = 1'b1;
    drive_p(4'h0, 16'd1, 16'd2);
    push(1'b0, 16'h0003);
    cyc();
    idle();
    check("flush_no_rsp", 32'(rsp_valid), 0);
    check("flush_flags", {30'd0, flag_z, flag_n}, 32'b01);
    cyc();
    check("flush_next_rsp", 32'(rsp_valid), 1);

    // Flushed branch is not reported.
    drive_p(4'h9, 16'd0, 16'd0);
    cyc();
    idle();
    flush = 1'b1;
    #1;
    check("flush_br_valid", 32'(br_valid), 0);
    cyc();
    idle();
    cyc();

    // Reset mid-flight: one response visible, one op in issue; both dropped.
    drive_p(4'h0, 16'd8, 16'd8);
    cyc();
    drive_p(4'h0, 16'd9, 16'd9);
    cyc();
    idle();
    rst = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_alu", {alu_sel, alu_a}, {4'hC, 16'h0000});
    check("rst_flags", {30'd0, flag_z, flag_n}, 0);
    cyc();
    rst = 1'b0;
    cyc();
    drive_p(4'h0, 16'h0010, 16'h0020);
    push(1'b0, 16'h0030);
    cyc();
    idle();
    check("post_rst_issue", 32'(rsp_valid), 0);
    cyc();
    check("post_rst_rsp", 32'(rsp_valid), 1);

    // Other opcodes back-to-back, then an auxiliary-only request.
    drive_p(4'h4, 16'h0001, 16'h0004);
    push(1'b0, 16'h0010);
    cyc();
    drive_p(4'hC, 16'h1234, 16'h0001);
    push(1'b0, 16'h0000);
    cyc();
    drive_p(4'hF, 16'h1234, 16'h0001);
    push(1'b0, 16'h0000);
    cyc();
    idle();
    x_valid = 1'b1; x_op = 4'h2; x_a = 16'hF0F0; x_b = 16'h0FF0;
    #1;
    check("aux_x_ready", 32'(x_ready), 1);
    push(1'b1, 16'h00F0);
    cyc();
    idle();
    cyc(); cyc(); cyc();
    check("other_flags", {30'd0, flag_z, flag_n}, 0);
    check("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Shares the single 16-bit execute-stage ALU between two requesters: the pipeline execute stage (primary, `p_*`) and an auxiliary port (`x_*`, used for address generation and debug). The primary port normally wins. A starvation guard forces an auxiliary grant after a bounded wait. The block registers the winning operation, drives the combinational ALU, and returns a registered response. It also owns the architectural Z/N flag register and resolves B/BEQ/BGE.

## Interface
- `DATA_W`, 16, operand/result width.
- `STARVE_LIMIT`, 4, consecutive cycles the auxiliary port may be refused before it is forced through; legal range 1..15.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `p_valid` / `p_ready`  in / out  1  primary request handshake.
- `p_op`  in  4  opcode, `alu_op_e`.
- `p_a`, `p_b`  in  DATA_W  primary operands.
- `x_valid` / `x_ready`  in / out  1  auxiliary request handshake.
- `x_op`  in  4  auxiliary opcode.
- `x_a`, `x_b`  in  DATA_W  auxiliary operands.
- `flush`  in  1  kills the operation in the issue stage.
- `alu_a`, `alu_b`  out  DATA_W  operands to the ALU.
- `alu_sel`  out  4  ALU select.
- `alu_out`  in  DATA_W  ALU result. The ALU's zero/negative outputs are not consumed.
- `rsp_valid`  out  1  response valid, one cycle, no backpressure.
- `rsp_id`  out  1  0 = primary, 1 = auxiliary.
- `rsp_data`  out  DATA_W  result.
- `flag_z`, `flag_n`  out  1  architectural flags.
- `br_valid`, `br_taken`  out  1  branch resolution for B/BEQ/BGE.

## Operation
Opcodes:
- ADD=0, SUB=1, AND=2, OR=3, LSL=4, CMP=5, SET=6, LDR=7, STR=8.
- B=9, BEQ=A, BGE=B, STALL=C.
- Other values behave as STALL.

Arbitration, evaluated each cycle:
- `force` = (starve count == STARVE_LIMIT) && `x_valid`.
- `x_ready` = `force` || !`p_valid`.
- `p_ready` = !`force`.
- Exactly one handshake completes per cycle at most.
- `p_ready` and `x_ready` do not depend on `flush` or on issue-stage occupancy; the block never back-pressures for internal reasons.

Starve counter:
- Increments, saturating at STARVE_LIMIT, when `x_valid` && !`x_ready`.
- Clears on an auxiliary handshake or when `x_valid` is low.

Issue stage (one register set: valid, id, op, a, b):
- Loads the granted request.
- Drives `alu_a`, `alu_b`, `alu_sel` = op.
- When empty it drives 0 and sel=STALL.

Response:
- `rsp_data` = `alu_out` for ops 0–8, and 0 for branch and STALL ops.

Flags:
- Written only when a CMP leaves the issue stage un-flushed.
- Z = (`alu_out` == 0), N = `alu_out[DATA_W-1]`.
- No other opcode modifies the flags.

Branches:
- Resolved in the issue stage from the current flag register.
- `br_taken`: B=1, BEQ = `flag_z`, BGE = !`flag_n`.
- `br_valid` is asserted combinationally for the issue cycle of a non-flushed branch op.

Flush:
- Clears issue valid at the next edge.
- No response, no flag write, `br_valid` = 0.
- A request handshaking in the same cycle as `flush` is still accepted.

## Timing
- Handshake in cycle N → issue in N+1 → `rsp_valid` in N+2. Latency 2, throughput 1 per cycle.
- CMP granted at N followed by BEQ at N+1: the BEQ sees the updated flags. Flags are written at the end of N+1 and read in N+2, so no hazard logic is required.
- Reset values, asynchronous:
  - all issue/response registers, `rsp_*`, `br_*` = 0;
  - `flag_z` = `flag_n` = 0;
  - starve count = 0;
  - `alu_sel` = STALL.
- Reset asserted mid-operation drops in-flight work with no response.

## Structure
- `alu_pkg`: `alu_op_e` enum, `DATA_W` default, `is_branch()` helper.
- Sub-module `alu_starve_guard`: saturating counter plus `force` output.
- Everything else stays in `alu_scheduler`.

## Test plan
- **Primary path:** primary ADD 0x0003+0x0004 alone → `rsp_valid` 2 cycles later, id=0, data=0x0007, flags unchanged at 0.
- **Starvation, STARVE_LIMIT=4:** `p_valid` and `x_valid` held high continuously → 4 primary grants, then 1 auxiliary grant, then the pattern repeats.
- **CMP equal then BEQ:** CMP 5,5 then BEQ back-to-back → `flag_z`=1 and `br_taken`=1. Then CMP 3,5 then BGE → `flag_n`=1 and `br_taken`=0.
- **Flush on CMP:** `flush` asserted while a CMP is in issue → no `rsp_valid` and flags unchanged. The request accepted that same cycle still responds.
- **Reset mid-flight:** `rst` pulsed while the issue stage is valid → all outputs 0 immediately; next request completes with normal 2-cycle latency.
- **Other opcodes:** LSL 0x0001,4 → 0x0010; STALL and unknown opcode 0xF → response data 0, no flag change.
